io_stim_gen: RTL and testbench

Parametrised switch-stimulus sequencer that drives `i_io_sw` of the pipelined RISC-V core in the top-level bench, replacing the fixed-pattern switch driver. It steps a programmable pattern sequence (constant, increment, walking-one, LFSR) across `STEPS` patterns, holding each for a programmable number of cycles. It reports progress and completion so the scoreboard can align its checks.

---
 rtl/io_stim_gen_if.sv | 40 ++++
 rtl/io_stim_gen.sv | 158 +++++++++++++++
 tb/tb_io_stim_gen.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_stim_gen_if.sv
// io_stim_gen_if: command/status bundle for the switch-stimulus sequencer.
//   slave  modport: seen by io_stim_gen (commands in, pattern/status out).
//   master modport: seen by whoever controls the sequencer.
// Signals:
//   i_start     run request, sampled only while the sequencer is idle
//   i_mode      0 constant, 1 increment, 2 walking-one, 3 Galois LFSR
//   i_seed      first pattern of a run
//   i_hold      counted cycles per pattern (0 behaves as 1)
//   i_insn_vld  retire strobe, only used when STIM_RETIRE_GATE_EN is defined
//   o_sw_data   current pattern
//   o_busy      high while a pattern is being held
//   o_done      one-cycle pulse after the last pattern
//   o_step_cnt  patterns fully completed in the current run
interface io_stim_gen_if #(
  parameter int WIDTH  = 32,
  parameter int STEPS  = 16,
  parameter int HOLD_W = 16
);
  localparam int CNT_W = $clog2(STEPS + 1);

  logic              i_start;
  logic [1:0]        i_mode;
  logic [WIDTH-1:0]  i_seed;
  logic [HOLD_W-1:0] i_hold;
  logic              i_insn_vld;
  logic [WIDTH-1:0]  o_sw_data;
  logic              o_busy;
  logic              o_done;
  logic [CNT_W-1:0]  o_step_cnt;

  modport master (
    output i_start, i_mode, i_seed, i_hold, i_insn_vld,
    input  o_sw_data, o_busy, o_done, o_step_cnt
  );

  modport slave (
    input  i_start, i_mode, i_seed, i_hold, i_insn_vld,
    output o_sw_data, o_busy, o_done, o_step_cnt
  );
endinterface

// File: rtl/io_stim_gen.sv
// io_stim_gen: switch-stimulus sequencer. Steps STEPS patterns (constant,
// increment, walking-one or Galois LFSR) and holds each one for a
// programmable number of counted cycles, reporting progress and completion.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-low reset
//   s_if     io_stim_gen_if.slave (start/mode/seed/hold/insn_vld in,
//            sw_data/busy/done/step_cnt out)
// Configuration macro:
//   STIM_RETIRE_GATE_EN  when defined, a HOLD cycle counts only while
//                        i_insn_vld is high; otherwise every HOLD cycle counts.
// All outputs are registered.
module io_stim_gen #(
  parameter int          WIDTH  = 32,
  parameter int          STEPS  = 16,
  parameter int          HOLD_W = 16,
  parameter logic [31:0] POLY   = 32'h8020_0003
) (
  input  logic         i_clk,
  input  logic         i_reset,
  io_stim_gen_if.slave s_if
);

  localparam int                CNT_W     = $clog2(STEPS + 1);
  localparam logic [WIDTH-1:0]  POLY_W    = WIDTH'(POLY);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_mode;
  logic [HOLD_W-1:0] r_hold_len;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [WIDTH-1:0]  r_data;
  logic [CNT_W-1:0]  r_step_cnt;
  logic              r_busy;
  logic              r_done;

  state_t            w_state;
  logic [1:0]        w_mode;
  logic [HOLD_W-1:0] w_hold_len;
  logic [HOLD_W-1:0] w_hold_cnt;
  logic [WIDTH-1:0]  w_data;
  logic [CNT_W-1:0]  w_step_cnt;
  logic              w_busy;
  logic              w_done;

  logic              w_count;
  logic [HOLD_W-1:0] w_start_len;
  logic [WIDTH-1:0]  w_seed_fix;

`ifdef STIM_RETIRE_GATE_EN
  assign w_count = s_if.i_insn_vld;
`else
  logic w_unused_insn;
  assign w_count       = 1'b1;
  assign w_unused_insn = s_if.i_insn_vld;
`endif

  // Zero hold behaves as a one-cycle hold.
  assign w_start_len = (s_if.i_hold == '0) ? HOLD_ONE : s_if.i_hold;

  // Walking-one and LFSR would be stuck on an all-zero seed.
  assign w_seed_fix = (s_if.i_mode[1] && (s_if.i_seed == '0)) ? WIDTH'(1) : s_if.i_seed;

  function automatic logic [WIDTH-1:0] f_advance(input logic [1:0] mode,
                                                 input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    case (mode)
      2'd0:    y = x;
      2'd1:    y = x + WIDTH'(1);
      2'd2:    y = {x[WIDTH-2:0], x[WIDTH-1]};
      default: y = x[0] ? ((x >> 1) ^ POLY_W) : (x >> 1);
    endcase
    return y;
  endfunction

  always_comb begin
    w_state    = r_state;
    w_mode     = r_mode;
    w_hold_len = r_hold_len;
    w_hold_cnt = r_hold_cnt;
    w_data     = r_data;
    w_step_cnt = r_step_cnt;

    case (r_state)
      S_IDLE: begin
        if (s_if.i_start) begin
          w_mode     = s_if.i_mode;
          w_hold_len = w_start_len;
          w_hold_cnt = w_start_len;
          w_data     = w_seed_fix;
          w_step_cnt = '0;
          w_state    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_count) begin
          if (r_hold_cnt == HOLD_ONE) begin
            w_step_cnt = r_step_cnt + 1'b1;
            // The last pattern stays on the outputs after the run ends.
            if (r_step_cnt == LAST_STEP) begin
              w_state = S_DONE;
            end else begin
              w_data     = f_advance(r_mode, r_data);
              w_hold_cnt = r_hold_len;
            end
          end else begin
            w_hold_cnt = r_hold_cnt - 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Status flags are decoded from the next state so they register alongside it.
    w_busy = (w_state == S_HOLD);
    w_done = (w_state == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_mode     <= '0;
      r_hold_len <= '0;
      r_hold_cnt <= '0;
      r_data     <= '0;
      r_step_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_mode     <= w_mode;
      r_hold_len <= w_hold_len;
      r_hold_cnt <= w_hold_cnt;
      r_data     <= w_data;
      r_step_cnt <= w_step_cnt;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign s_if.o_sw_data  = r_data;
  assign s_if.o_busy     = r_busy;
  assign s_if.o_done     = r_done;
  assign s_if.o_step_cnt = r_step_cnt;

endmodule

// File: tb/tb_io_stim_gen.sv
// Bench for io_stim_gen: two instances (8-bit/4-step and 4-bit/6-step) run
// the same commands and are compared every cycle against a pattern-list model.
module tb_io_stim_gen;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  io_stim_gen_if #(.WIDTH(8), .STEPS(4), .HOLD_W(16)) a_if ();
  io_stim_gen_if #(.WIDTH(4), .STEPS(6), .HOLD_W(16)) b_if ();

  io_stim_gen #(.WIDTH(8), .STEPS(4), .HOLD_W(16), .POLY(32'h0000_008E)) u_a (
    .i_clk   (clk),
    .i_reset (rst_n),
    .s_if    (a_if)
  );

  io_stim_gen #(.WIDTH(4), .STEPS(6), .HOLD_W(16), .POLY(32'h0000_000C)) u_b (
    .i_clk   (clk),
    .i_reset (rst_n),
    .s_if    (b_if)
  );

  always #5 clk = ~clk;

  // Model: ph 0 = holding (c counted cycles so far), 1 = done pulse, 2 = idle.
  typedef struct {
    int          w;
    int          steps;
    logic [31:0] poly;
    logic [1:0]  mode;
    logic [31:0] seed;
    int          hl;
    int          c;
    int          ph;
    logic [31:0] idle_d;
    int          idle_s;
  } mdl_t;

  mdl_t m [2];

  function automatic logic [31:0] msk(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // k-th pattern of the current run, computed from the seed.
  function automatic logic [31:0] pat(input int i, input int k);
    logic [31:0] x;
    logic [31:0] mk;
    mk = msk(m[i].w);
    x  = m[i].seed & mk;
    if (m[i].mode >= 2'd2 && x == 32'd0) x = 32'd1;
    for (int j = 0; j < k; j++) begin
      case (m[i].mode)
        2'd0:    x = x;
        2'd1:    x = (x + 32'd1) & mk;
        2'd2:    x = ((x << 1) | (x >> (m[i].w - 1))) & mk;
        default: x = x[0] ? ((x >> 1) ^ (m[i].poly & mk)) : (x >> 1);
      endcase
    end
    return x;
  endfunction

  function automatic void mdl_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].mode   = 2'd0;
      m[i].seed   = 32'd0;
      m[i].hl     = 1;
      m[i].c      = 0;
      m[i].ph     = 2;
      m[i].idle_d = 32'd0;
      m[i].idle_s = 0;
    end
  endfunction

  function automatic void upd(input int i, input bit s, input logic [1:0] md,
                              input logic [31:0] sd, input int hd, input bit iv);
    bit cnt;
`ifdef STIM_RETIRE_GATE_EN
    cnt = iv;
`else
    cnt = 1'b1 | iv;
`endif
    case (m[i].ph)
      0: begin
        if (cnt) begin
          m[i].c++;
          if (m[i].c == m[i].steps * m[i].hl) begin
            m[i].ph     = 1;
            m[i].idle_d = pat(i, m[i].steps - 1);
            m[i].idle_s = m[i].steps;
          end
        end
      end
      1: m[i].ph = 2;
      default: begin
        if (s) begin
          m[i].mode = md;
          m[i].seed = sd & msk(m[i].w);
          m[i].hl   = (hd == 0) ? 1 : hd;
          m[i].c    = 0;
          m[i].ph   = 0;
        end
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_dut(input int i);
    logic [31:0] ed;
    logic [31:0] eb;
    logic [31:0] edn;
    logic [31:0] es;
    case (m[i].ph)
      0: begin
        ed = pat(i, m[i].c / m[i].hl); eb = 1; edn = 0; es = 32'(m[i].c / m[i].hl);
      end
      1: begin
        ed = m[i].idle_d; eb = 0; edn = 1; es = 32'(m[i].idle_s);
      end
      default: begin
        ed = m[i].idle_d; eb = 0; edn = 0; es = 32'(m[i].idle_s);
      end
    endcase
    if (i == 0) begin
      chk("A.data", 32'(a_if.o_sw_data), ed);
      chk("A.busy", 32'(a_if.o_busy), eb);
      chk("A.done", 32'(a_if.o_done), edn);
      chk("A.step", 32'(a_if.o_step_cnt), es);
    end else begin
      chk("B.data", 32'(b_if.o_sw_data), ed);
      chk("B.busy", 32'(b_if.o_busy), eb);
      chk("B.done", 32'(b_if.o_done), edn);
      chk("B.step", 32'(b_if.o_step_cnt), es);
    end
  endtask

  // One clock: drive from a negedge, model the posedge, check at next negedge.
  task automatic step(input bit s, input logic [1:0] md, input logic [31:0] sd,
                      input int hd, input bit iv);
    a_if.i_start    = s;        b_if.i_start    = s;
    a_if.i_mode     = md;       b_if.i_mode     = md;
    a_if.i_seed     = sd[7:0];  b_if.i_seed     = sd[3:0];
    a_if.i_hold     = 16'(hd);  b_if.i_hold     = 16'(hd);
    a_if.i_insn_vld = iv;       b_if.i_insn_vld = iv;
    @(posedge clk);
    upd(0, s, md, sd, hd, iv);
    upd(1, s, md, sd, hd, iv);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  // spol: 0 start on first cycle only, 1 held high, 2 random pulses.
  // ipol: 0 insn always 1, 1 toggling, 2 random, 3 stuck at 0.
  task automatic run(input logic [1:0] md, input logic [31:0] sd, input int hd,
                     input int spol, input int ipol, input bit cfg_rand, input int ncyc);
    logic [1:0]  cm;
    logic [31:0] cs;
    int          ch;
    bit          cst;
    bit          civ;
    int          guard;
    cm = md; cs = sd; ch = hd;
    for (int n = 0; n < ncyc; n++) begin
      cst = (n == 0) || (spol == 1) || (spol == 2 && $urandom_range(0, 3) == 0);
      if (cfg_rand && n > 0) begin
        cm = 2'($urandom_range(0, 3));
        cs = $urandom;
        ch = $urandom_range(0, 3);
      end
      case (ipol)
        0:       civ = 1'b1;
        1:       civ = (n % 2 == 0);
        2:       civ = 1'($urandom_range(0, 1));
        default: civ = 1'b0;
      endcase
      step(cst, cm, cs, ch, civ);
    end
    guard = 0;
    while (!(m[0].ph == 2 && m[1].ph == 2) && guard < 2000) begin
      step(1'b0, cm, cs, ch, 1'b1);
      guard++;
    end
    chk("drain_idle", 32'(m[0].ph == 2 && m[1].ph == 2), 32'd1);
  endtask

  initial begin
    int guard;
    clk   = 1'b0;
    rst_n = 1'b0;
    total = 0;
    bad   = 0;
    a_if.i_start = 1'b0; a_if.i_mode = '0; a_if.i_seed = '0; a_if.i_hold = '0; a_if.i_insn_vld = 1'b0;
    b_if.i_start = 1'b0; b_if.i_mode = '0; b_if.i_seed = '0; b_if.i_hold = '0; b_if.i_insn_vld = 1'b0;
    mdl_reset();
    m[0].w = 8; m[0].steps = 4; m[0].poly = 32'h0000_008E;
    m[1].w = 4; m[1].steps = 6; m[1].poly = 32'h0000_000C;

    repeat (2) @(negedge clk);
    check_dut(0);
    check_dut(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Increment wrap: A sees FE,FF,00,01 with hold 2.
    run(2'd1, 32'h0000_00FE, 2, 0, 0, 1'b0, 1);
    // Walking-one from zero seed.
    run(2'd2, 32'h0, 1, 0, 0, 1'b0, 1);
    // LFSR from seed 1 and from seed 0 (fixup to 1).
    run(2'd3, 32'h1, 1, 0, 0, 1'b0, 1);
    run(2'd3, 32'h0, 1, 0, 0, 1'b0, 1);
    // Constant mode.
    run(2'd0, 32'h0000_005A, 3, 0, 0, 1'b0, 1);
    // Hold 0, random start pulses and config changes mid-run.
    run(2'd1, 32'h0000_0033, 0, 2, 0, 1'b1, 20);
    // Start held high: back-to-back runs.
    run(2'd3, 32'h0000_00A7, 1, 1, 0, 1'b0, 30);
    // Retire strobe toggling every other cycle.
    run(2'd2, 32'h1, 3, 0, 1, 1'b0, 40);
    // Retire strobe stuck low for a while.
    run(2'd1, 32'h5, 2, 0, 3, 1'b0, 15);
    // Random runs.
    repeat (10) begin
      run(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3), 2, 2, 1'b1, 30);
    end

    // Reset mid-run once B has completed 5 patterns.
    step(1'b1, 2'd1, 32'h3, 2, 1'b1);
    guard = 0;
    while (!(m[1].ph == 0 && m[1].c / m[1].hl == 5) && guard < 200) begin
      step(1'b0, 2'd1, 32'h3, 2, 1'b1);
      guard++;
    end
    chk("B.step_before_reset", 32'(b_if.o_step_cnt), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    mdl_reset();
    check_dut(0);
    check_dut(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    rst_n = 1'b1;
    run(2'd1, 32'h3, 2, 0, 0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
